pic_core_stk: RTL and testbench

Parametrised successor to the 14-bit-ISA multicycle accumulator CPU. Keeps the PIC-style literal, byte-file, bit and skip instruction set, and adds:
- a hardware call stack (CALL/RETURN/RETLW);
- a STATUS register with Z and C flags.
Program ROM and data RAM move outside the core behind simple synchronous-write / combinational-read ports, so one core serves several memory configurations.

---
 rtl/pic_core_pkg.sv | 66 ++++++
 rtl/pic_call_stack.sv | 53 +++++
 rtl/pic_core_stk.sv | 249 ++++++++++++++++++++++++
 tb/tb_pic_core_stk.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_core_pkg.sv
// pic_core_pkg: shared types and opcode fields for the pic_core_stk CPU.
// FSM states, ALU op codes, instruction-class/field constants, STATUS bits.
package pic_core_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_INC,
        S_LOAD,
        S_EXEC,
        S_SLEEP
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_IOR,
        ALU_XOR,
        ALU_PASS,
        ALU_INC,
        ALU_DEC,
        ALU_CLR,
        ALU_COM
    } alu_op_t;

    // instruction class, ir[13:12]
    localparam logic [1:0] CLS_FILE = 2'b00;
    localparam logic [1:0] CLS_BIT  = 2'b01;
    localparam logic [1:0] CLS_BRA  = 2'b10;
    localparam logic [1:0] CLS_LIT  = 2'b11;

    // byte-file ops, ir[11:8]
    localparam logic [3:0] F_MISC   = 4'h0;
    localparam logic [3:0] F_CLR    = 4'h1;
    localparam logic [3:0] F_SUBWF  = 4'h2;
    localparam logic [3:0] F_DECF   = 4'h3;
    localparam logic [3:0] F_IORWF  = 4'h4;
    localparam logic [3:0] F_ANDWF  = 4'h5;
    localparam logic [3:0] F_XORWF  = 4'h6;
    localparam logic [3:0] F_ADDWF  = 4'h7;
    localparam logic [3:0] F_MOVF   = 4'h8;
    localparam logic [3:0] F_COMF   = 4'h9;
    localparam logic [3:0] F_INCF   = 4'hA;
    localparam logic [3:0] F_DECFSZ = 4'hB;
    localparam logic [3:0] F_INCFSZ = 4'hF;

    // bit ops, ir[11:10]
    localparam logic [1:0] B_BCF   = 2'b00;
    localparam logic [1:0] B_BSF   = 2'b01;
    localparam logic [1:0] B_BTFSC = 2'b10;
    localparam logic [1:0] B_BTFSS = 2'b11;

    // literal ops, ir[11:8]
    localparam logic [3:0] L_IORLW = 4'h8;
    localparam logic [3:0] L_ANDLW = 4'h9;
    localparam logic [3:0] L_XORLW = 4'hA;

    // F_MISC low byte
    localparam logic [7:0] LO_RETURN = 8'h08;
    localparam logic [7:0] LO_SLEEP  = 8'h63;

    // STATUS bit indices
    localparam int ST_Z = 0;
    localparam int ST_C = 1;

endpackage

// File: rtl/pic_call_stack.sv
// pic_call_stack: circular return-address stack with sticky overflow/underflow.
// Ports: clk, reset (async active-low), push/pop, din/dout, ovf/unf flags.
module pic_call_stack
    import pic_core_pkg::*;
#(
    parameter int PC_W        = 11,
    parameter int STACK_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] dout,
    output logic            ovf,
    output logic            unf
);

    localparam int SP_W = $clog2(STACK_DEPTH);
    localparam logic [SP_W-1:0] SP_ONE = 1;
    localparam logic [SP_W:0]   CNT_ONE = 1;
    localparam logic [SP_W:0]   CNT_FULL = STACK_DEPTH;

    logic [PC_W-1:0] mem [STACK_DEPTH];
    logic [SP_W-1:0] sp;
    logic [SP_W-1:0] sp_dec;
    logic [SP_W:0]   cnt;

    assign sp_dec = sp - SP_ONE;
    // pop on empty still reads the wrapped slot
    assign dout   = mem[sp_dec];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STACK_DEPTH; i++) mem[i] <= '0;
            sp  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (push) begin
            mem[sp] <= din;
            sp      <= sp + SP_ONE;
            // full: oldest entry is overwritten, depth stays saturated
            if (cnt == CNT_FULL) ovf <= 1'b1;
            else                 cnt <= cnt + CNT_ONE;
        end else if (pop) begin
            sp <= sp_dec;
            if (cnt == '0) unf <= 1'b1;
            else           cnt <= cnt - CNT_ONE;
        end
    end

endmodule

// File: rtl/pic_core_stk.sv
// pic_core_stk: 4-clock multicycle PIC-style CPU with call stack and {C,Z}.
// Ports: clk, reset (async active-low), rom_addr/rom_data, ram_addr/ram_rdata/
// ram_wdata/ram_we, w_q, status {C,Z}, stk_ovf, stk_unf, wake.
// Optional: define PIC_CORE_SLEEP_EN to enable SLEEP / S_SLEEP / wake.
module pic_core_stk
    import pic_core_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int PC_W        = 11,
    parameter int RAM_AW      = 7,
    parameter int STACK_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic [PC_W-1:0]   rom_addr,
    input  logic [13:0]       rom_data,
    output logic [RAM_AW-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic [DATA_W-1:0] w_q,
    output logic [1:0]        status,
    output logic              stk_ovf,
    output logic              stk_unf,
    input  logic              wake
);

    localparam logic [PC_W-1:0]   PC_ONE = 1;
    localparam logic [DATA_W-1:0] D_ONE  = 1;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, mar_q, stk_dout;
    logic [13:0]     ir_q;
    logic            ex;

    alu_op_t op;
    logic    use_lit, wr_w, wr_ram, upd_z, upd_c;
    logic    bit_set, bit_clr, skip_z, skip_bc, skip_bs;
    logic    do_goto, do_call, do_ret, do_retlw, do_movwf;
`ifdef PIC_CORE_SLEEP_EN
    logic    do_sleep;
`else
    logic    unused_wake;
    assign unused_wake = wake;
`endif

    logic [DATA_W-1:0] lit, a, res, mask;
    logic [DATA_W:0]   sum;
    logic              cout, res_zero, bitv, skip;

    assign ex       = (state_q == S_EXEC);
    assign rom_addr = mar_q;
    assign ram_addr = ir_q[RAM_AW-1:0];
    assign lit      = DATA_W'(ir_q[7:0]);

    // decode
    always_comb begin
        op       = ALU_PASS;
        use_lit  = 1'b0;
        wr_w     = 1'b0;
        wr_ram   = 1'b0;
        upd_z    = 1'b0;
        upd_c    = 1'b0;
        bit_set  = 1'b0;
        bit_clr  = 1'b0;
        skip_z   = 1'b0;
        skip_bc  = 1'b0;
        skip_bs  = 1'b0;
        do_goto  = 1'b0;
        do_call  = 1'b0;
        do_ret   = 1'b0;
        do_retlw = 1'b0;
        do_movwf = 1'b0;
`ifdef PIC_CORE_SLEEP_EN
        do_sleep = 1'b0;
`endif
        unique case (ir_q[13:12])
            CLS_FILE: begin
                wr_w   = !ir_q[7];
                wr_ram = ir_q[7];
                upd_z  = 1'b1;
                case (ir_q[11:8])
                    F_MISC: begin
                        upd_z    = 1'b0;
                        wr_w     = 1'b0;
                        do_movwf = ir_q[7];
                        do_ret   = (ir_q[7:0] == LO_RETURN);
`ifdef PIC_CORE_SLEEP_EN
                        do_sleep = (ir_q[7:0] == LO_SLEEP);
`endif
                    end
                    F_CLR:   op = ALU_CLR;
                    F_SUBWF: begin op = ALU_SUB; upd_c = 1'b1; end
                    F_DECF:  op = ALU_DEC;
                    F_IORWF: op = ALU_IOR;
                    F_ANDWF: op = ALU_AND;
                    F_XORWF: op = ALU_XOR;
                    F_ADDWF: begin op = ALU_ADD; upd_c = 1'b1; end
                    F_MOVF:  op = ALU_PASS;
                    F_COMF:  op = ALU_COM;
                    F_INCF:  op = ALU_INC;
                    F_DECFSZ: begin
                        op = ALU_DEC; upd_z = 1'b0; skip_z = 1'b1;
                    end
                    F_INCFSZ: begin
                        op = ALU_INC; upd_z = 1'b0; skip_z = 1'b1;
                    end
                    default: begin
                        wr_w = 1'b0; wr_ram = 1'b0; upd_z = 1'b0;
                    end
                endcase
            end
            CLS_BIT: begin
                unique case (ir_q[11:10])
                    B_BCF:   begin bit_clr = 1'b1; wr_ram = 1'b1; end
                    B_BSF:   begin bit_set = 1'b1; wr_ram = 1'b1; end
                    B_BTFSC: skip_bc = 1'b1;
                    B_BTFSS: skip_bs = 1'b1;
                endcase
            end
            CLS_BRA: begin
                do_goto = ir_q[11];
                do_call = !ir_q[11];
            end
            CLS_LIT: begin
                use_lit = 1'b1;
                wr_w    = 1'b1;
                upd_z   = 1'b1;
                case (ir_q[11:8])
                    4'h0, 4'h1, 4'h2, 4'h3: begin
                        op = ALU_PASS; upd_z = 1'b0;
                    end
                    4'h4, 4'h5, 4'h6, 4'h7: begin
                        do_retlw = 1'b1; wr_w = 1'b0; upd_z = 1'b0;
                    end
                    L_IORLW: op = ALU_IOR;
                    L_ANDLW: op = ALU_AND;
                    L_XORLW: op = ALU_XOR;
                    4'hC, 4'hD: begin op = ALU_SUB; upd_c = 1'b1; end
                    4'hE, 4'hF: begin op = ALU_ADD; upd_c = 1'b1; end
                    default: begin wr_w = 1'b0; upd_z = 1'b0; end
                endcase
            end
        endcase
    end

    // ALU; subtraction is operand minus W, C = no borrow
    assign a = use_lit ? lit : ram_rdata;

    always_comb begin
        sum  = '0;
        cout = 1'b0;
        case (op)
            ALU_ADD: begin
                sum  = {1'b0, a} + {1'b0, w_q};
                cout = sum[DATA_W];
            end
            ALU_SUB: begin
                sum  = {1'b0, a} - {1'b0, w_q};
                cout = !sum[DATA_W];
            end
            ALU_AND:  sum = {1'b0, a & w_q};
            ALU_IOR:  sum = {1'b0, a | w_q};
            ALU_XOR:  sum = {1'b0, a ^ w_q};
            ALU_INC:  sum = {1'b0, a + D_ONE};
            ALU_DEC:  sum = {1'b0, a - D_ONE};
            ALU_CLR:  sum = '0;
            ALU_COM:  sum = {1'b0, ~a};
            default:  sum = {1'b0, a};
        endcase
    end

    assign res      = sum[DATA_W-1:0];
    assign res_zero = (res == '0);
    assign mask     = D_ONE << ir_q[9:7];
    assign bitv     = |(ram_rdata & mask);
    assign skip     = (skip_z & res_zero) | (skip_bc & !bitv)
                    | (skip_bs & bitv);

    always_comb begin
        ram_wdata = res;
        if (do_movwf)     ram_wdata = w_q;
        else if (bit_set) ram_wdata = ram_rdata | mask;
        else if (bit_clr) ram_wdata = ram_rdata & ~mask;
    end

    assign ram_we = ex & wr_ram;

    // FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: state_d = S_INC;
            S_INC:   state_d = S_LOAD;
            S_LOAD:  state_d = S_EXEC;
`ifdef PIC_CORE_SLEEP_EN
            S_EXEC:  state_d = do_sleep ? S_SLEEP : S_FETCH;
            S_SLEEP: state_d = wake ? S_FETCH : S_SLEEP;
`else
            S_EXEC:  state_d = S_FETCH;
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q   <= '0;
            mar_q  <= '0;
            ir_q   <= '0;
            w_q    <= '0;
            status <= '0;
        end else begin
            if (state_q == S_FETCH) mar_q <= pc_q;
            if (state_q == S_INC)   pc_q  <= pc_q + PC_ONE;
            if (state_q == S_LOAD)  ir_q  <= rom_data;
            if (ex) begin
                if (wr_w)     w_q <= res;
                if (do_retlw) w_q <= lit;
                if (upd_z)    status[ST_Z] <= res_zero;
                if (upd_c)    status[ST_C] <= cout;
                if (do_goto | do_call)      pc_q <= ir_q[PC_W-1:0];
                else if (do_ret | do_retlw) pc_q <= stk_dout;
                else if (skip)              pc_q <= pc_q + PC_ONE;
            end
        end
    end

    pic_call_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (ex & do_call),
        .pop   (ex & (do_ret | do_retlw)),
        .din   (pc_q),
        .dout  (stk_dout),
        .ovf   (stk_ovf),
        .unf   (stk_unf)
    );

endmodule

// File: tb/tb_pic_core_stk.sv
// tb_pic_core_stk: directed self-checking bench for pic_core_stk.
// Small programs in a behavioural ROM/RAM, hand-computed expectations.
module tb_pic_core_stk;
    import pic_core_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [10:0] rom_addr;
    logic [13:0] rom_data;
    logic [6:0]  ram_addr;
    logic [7:0]  ram_rdata, ram_wdata, w_q;
    logic        ram_we, stk_ovf, stk_unf;
    logic [1:0]  status;
    logic        wake = 1'b0;

    logic [13:0] rom [0:2047];
    logic [7:0]  ram [0:127];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pic_core_stk #(
        .DATA_W(8), .PC_W(11), .RAM_AW(7), .STACK_DEPTH(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .ram_addr  (ram_addr),
        .ram_rdata (ram_rdata),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .w_q       (w_q),
        .status    (status),
        .stk_ovf   (stk_ovf),
        .stk_unf   (stk_unf),
        .wake      (wake)
    );

    assign rom_data  = rom[rom_addr];
    assign ram_rdata = ram[ram_addr];

    always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_wdata;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mem;
        for (int i = 0; i < 2048; i++) rom[i] = 14'h0000;
        for (int i = 0; i < 128; i++) ram[i] <= 8'h00;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        step(1);
        reset = 1'b1;
    endtask

    initial begin
        logic [10:0] ret_exp [5];
        ret_exp[0] = 11'h041; ret_exp[1] = 11'h031; ret_exp[2] = 11'h021;
        ret_exp[3] = 11'h011; ret_exp[4] = 11'h041;

        // MOVLW 05; ADDLW FB
        clear_mem();
        rom[0] = 14'h3005;
        rom[1] = 14'h3EFB;
        do_reset();
        check("rst_w", w_q, 8'h00);
        check("rst_status", status, 2'b00);
        check("rst_rom_addr", rom_addr, 11'h000);
        check("rst_we", ram_we, 1'b0);
        check("rst_ovf", stk_ovf, 1'b0);
        check("rst_unf", stk_unf, 1'b0);
        check("rst_state", dut.state_q, S_FETCH);
        step(4);
        check("movlw_w", w_q, 8'h05);
        check("movlw_status", status, 2'b00);
        step(4);
        check("addlw_w", w_q, 8'h00);
        check("addlw_status", status, 2'b11);

        // MOVLW 3; MOVWF 10; DECFSZ 10,1 x3; skipped MOVLW EE; MOVLW 55
        clear_mem();
        rom[0] = 14'h3003;
        rom[1] = 14'h0090;
        rom[2] = 14'h0B90;
        rom[3] = 14'h0B90;
        rom[4] = 14'h0B90;
        rom[5] = 14'h30EE;
        rom[6] = 14'h3055;
        do_reset();
        step(8);
        check("movwf_ram", ram[16], 8'h03);
        step(4);
        check("decfsz1", ram[16], 8'h02);
        step(4);
        check("decfsz2", ram[16], 8'h01);
        step(4);
        check("decfsz3", ram[16], 8'h00);
        check("decfsz_status", status, 2'b00);
        step(1);
        check("decfsz_skip_pc", rom_addr, 11'h006);
        step(3);
        check("decfsz_after_w", w_q, 8'h55);

        // CALL 020; MOVLW 11 at 1; RETLW 7A at 020
        clear_mem();
        rom[0]     = 14'h2020;
        rom[1]     = 14'h3011;
        rom[11'h20] = 14'h347A;
        do_reset();
        step(5);
        check("call_target", rom_addr, 11'h020);
        step(3);
        check("retlw_w", w_q, 8'h7A);
        step(1);
        check("retlw_pc", rom_addr, 11'h001);
        check("retlw_ovf", stk_ovf, 1'b0);
        check("retlw_unf", stk_unf, 1'b0);
        step(3);
        check("after_ret_w", w_q, 8'h11);

        // five nested CALLs into a depth-4 stack, then five RETURNs
        clear_mem();
        rom[11'h000] = 14'h2010;
        rom[11'h010] = 14'h2020;
        rom[11'h020] = 14'h2030;
        rom[11'h030] = 14'h2040;
        rom[11'h040] = 14'h2050;
        rom[11'h050] = 14'h0008;
        rom[11'h041] = 14'h0008;
        rom[11'h031] = 14'h0008;
        rom[11'h021] = 14'h0008;
        rom[11'h011] = 14'h0008;
        do_reset();
        step(20);
        check("nest_ovf", stk_ovf, 1'b1);
        check("nest_unf0", stk_unf, 1'b0);
        step(1);
        check("nest_deep_pc", rom_addr, 11'h050);
        for (int k = 0; k < 5; k++) begin
            if (k == 4) check("nest_unf_before", stk_unf, 1'b0);
            step(4);
            check($sformatf("ret%0d_pc", k), rom_addr, ret_exp[k]);
        end
        check("nest_unf", stk_unf, 1'b1);
        check("nest_ovf_sticky", stk_ovf, 1'b1);

        // BSF 20,7; BTFSS 20,7; skip; BCF 20,7; BTFSC 20,7; skip; MOVLW 42
        clear_mem();
        rom[0] = 14'h17A0;
        rom[1] = 14'h1FA0;
        rom[2] = 14'h30EE;
        rom[3] = 14'h13A0;
        rom[4] = 14'h1BA0;
        rom[5] = 14'h30DD;
        rom[6] = 14'h3042;
        ram[32] <= 8'h01;
        do_reset();
        step(4);
        check("bsf_ram", ram[32], 8'h81);
        step(5);
        check("btfss_skip_pc", rom_addr, 11'h003);
        step(3);
        check("bcf_ram", ram[32], 8'h01);
        step(5);
        check("btfsc_skip_pc", rom_addr, 11'h006);
        step(3);
        check("bit_after_w", w_q, 8'h42);

        // MOVLW FF; ADDLW 02; SUBLW 00; COMF 10,0; DECF 10,1
        clear_mem();
        rom[0] = 14'h30FF;
        rom[1] = 14'h3E02;
        rom[2] = 14'h3C00;
        rom[3] = 14'h0910;
        rom[4] = 14'h0390;
        ram[16] <= 8'hFF;
        do_reset();
        step(8);
        check("addlw_c_w", w_q, 8'h01);
        check("addlw_c_st", status, 2'b10);
        step(4);
        check("sublw_w", w_q, 8'hFF);
        check("sublw_st", status, 2'b00);
        step(4);
        check("comf_w", w_q, 8'h00);
        check("comf_st", status, 2'b01);
        check("comf_ram", ram[16], 8'hFF);
        step(4);
        check("decf_ram", ram[16], 8'hFE);
        check("decf_st", status, 2'b00);

        // reset in the middle of ADDWF 10,1
        clear_mem();
        rom[0] = 14'h3030;
        rom[1] = 14'h0790;
        ram[16] <= 8'hF0;
        do_reset();
        step(7);
        check("addwf_we", ram_we, 1'b1);
        check("addwf_wdata", ram_wdata, 8'h20);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_we", ram_we, 1'b0);
        check("mid_rst_w", w_q, 8'h00);
        check("mid_rst_state", dut.state_q, S_FETCH);
        step(1);
        check("mid_rst_ram", ram[16], 8'hF0);
        reset = 1'b1;

`ifdef PIC_CORE_SLEEP_EN
        // SLEEP with wake during its own EXEC, then a wake pulse
        clear_mem();
        rom[0] = 14'h0063;
        rom[1] = 14'h3066;
        do_reset();
        step(3);
        wake = 1'b1;
        step(1);
        wake = 1'b0;
        step(4);
        check("sleep_state", dut.state_q, S_SLEEP);
        check("sleep_rom_addr", rom_addr, 11'h000);
        check("sleep_we", ram_we, 1'b0);
        check("sleep_w", w_q, 8'h00);
        wake = 1'b1;
        step(1);
        wake = 1'b0;
        check("wake_state", dut.state_q, S_FETCH);
        step(1);
        check("wake_pc", rom_addr, 11'h001);
        step(3);
        check("wake_w", w_q, 8'h66);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
